// File: rtl/video_mem_pkg.sv
// Shared constants and types for the video memory time-slot sequencer.
// Defines the slot map of one 16-clock character period and default bases.
// Imported by the sequencer top and the video fetch slot.
package video_mem_pkg;

   // Slot bases within the 16-phase character period
   localparam logic [3:0] CPU_SLOT_A = 4'd0;
   localparam logic [3:0] VRAM_SLOT  = 4'd4;
   localparam logic [3:0] CPU_SLOT_B = 4'd8;
   localparam logic [3:0] CROM_SLOT  = 4'd12;

   // Every slot lasts four clocks; LAST_OFS is the final offset inside a slot
   localparam int         SLOT_LEN = 4;
   localparam logic [1:0] LAST_OFS = 2'(SLOT_LEN - 1);

   // Default physical memory map
   localparam int          DEF_ADDR_WIDTH   = 17;
   localparam logic [16:0] DEF_VRAM_BASE    = 17'h08000;
   localparam logic [16:0] DEF_CHARROM_BASE = 17'h10000;

   // CPU slot activity
   typedef enum logic [1:0] {
      CPU_IDLE  = 2'd0,
      CPU_READ  = 2'd1,
      CPU_WRITE = 2'd2
   } cpu_state_t;

   // True when a phase lies inside the four-clock slot starting at base
   function automatic logic in_slot(input logic [3:0] phase, input logic [3:0] base);
      return phase[3:2] == base[3:2];
   endfunction

endpackage

// File: rtl/video_fetch_slot.sv
// One video fetch slot: strobe generation, address mapping and capture timing.
// Latency: strobe rises entering base, address valid base+1, capture entering base+3.
// Backpressure: none; the slot runs on the fixed phase schedule.
module video_fetch_slot
   import video_mem_pkg::*;
#(
   parameter logic [3:0]  BASE         = VRAM_SLOT,
   parameter int          ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] VRAM_BASE    = DEF_VRAM_BASE,
   parameter logic [ADDR_WIDTH-1:0] CHARROM_BASE = DEF_CHARROM_BASE
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [3:0]            next_phase,
   input  logic                  video_en,
   input  logic [11:0]           video_addr,
   output logic                  strobe,
   output logic                  addr_load,
   output logic [ADDR_WIDTH-1:0] addr_map,
   output logic                  oe_next,
   output logic                  capture
);

   logic       slot_next;
   logic [1:0] ofs_next;

   assign slot_next = in_slot(next_phase, BASE);
   assign ofs_next  = next_phase[1:0];

   // The strobe doubles as the "slot enabled" flag: video_en is sampled only
   // at the base edge, so a mid-slot change never truncates the pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         strobe <= 1'b0;
      else if (!slot_next)
         strobe <= 1'b0;
      else if (ofs_next == 2'd0)
         strobe <= video_en;
   end

   // Address map: bit 11 selects the character ROM image, else video RAM
   always_comb begin
      addr_map = video_addr[11]
               ? CHARROM_BASE + {{(ADDR_WIDTH-11){1'b0}}, video_addr[10:0]}
               : VRAM_BASE    + {{(ADDR_WIDTH-11){1'b0}}, video_addr[10:0]};
   end

   // The generator gets the base phase to settle video_addr before we latch it
   assign addr_load = slot_next && strobe && (ofs_next == 2'd1);
   assign oe_next   = slot_next && strobe && (ofs_next != 2'd0);
   assign capture   = slot_next && strobe && (ofs_next == LAST_OFS);

endmodule

// File: rtl/video_mem_sequencer.sv
// Time-slot sequencer sharing one SRAM between CPU and video fetches.
// Latency: CPU ack 4 clocks after grant; grant wait up to 8 clocks.
// Backpressure: cpu_req is a level held until cpu_ack; video never stalls.
module video_mem_sequencer
   import video_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] VRAM_BASE    = DEF_VRAM_BASE,
   parameter logic [ADDR_WIDTH-1:0] CHARROM_BASE = DEF_CHARROM_BASE
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  video_en,
   input  logic [11:0]           video_addr,
   output logic [7:0]            video_data,
   output logic                  video_ram_strobe,
   output logic                  video_rom_strobe,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [15:0]           cpu_addr,
   input  logic [7:0]            cpu_wdata,
   output logic [7:0]            cpu_rdata,
   output logic                  cpu_ack,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_wdata,
   input  logic [7:0]            mem_rdata,
   output logic                  mem_oe,
   output logic                  mem_we
);

   logic [3:0]            phase;
   logic [3:0]            next_phase;
   cpu_state_t            state;
   cpu_state_t            state_nxt;
   logic                  cpu_slot_next;
   logic                  cpu_grant;
   logic                  cpu_oe_nxt;
   logic                  cpu_we_nxt;
   logic                  cpu_ack_nxt;
   logic                  cpu_rcap;
   logic                  ram_load;
   logic                  rom_load;
   logic                  ram_oe_nxt;
   logic                  rom_oe_nxt;
   logic                  ram_cap;
   logic                  rom_cap;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [ADDR_WIDTH-1:0] rom_addr;

   // Every output is registered, so all decisions look at the phase being entered
   assign next_phase = phase + 4'd1;

   // Free-running character-period counter; reset parks it at 15 so the
   // first edge after release enters phase 0, a CPU grant edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         phase <= 4'd15;
      else
         phase <= next_phase;
   end

   // CPU access state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= CPU_IDLE;
      else
         state <= state_nxt;
   end

   // CPU slot next-state and per-phase strobes; both CPU slots share this logic
   always_comb begin
      state_nxt   = state;
      cpu_grant   = 1'b0;
      cpu_oe_nxt  = 1'b0;
      cpu_we_nxt  = 1'b0;
      cpu_ack_nxt = 1'b0;
      cpu_rcap    = 1'b0;

      cpu_slot_next = in_slot(next_phase, CPU_SLOT_A) || in_slot(next_phase, CPU_SLOT_B);

      if (!cpu_slot_next) begin
         state_nxt = CPU_IDLE;
      end else if (next_phase[1:0] == 2'd0) begin
         cpu_grant = cpu_req;
         if (!cpu_req)
            state_nxt = CPU_IDLE;
         else if (cpu_we)
            state_nxt = CPU_WRITE;
         else
            state_nxt = CPU_READ;
      end

      case (state_nxt)
         CPU_READ: begin
            cpu_oe_nxt  = (next_phase[1:0] != LAST_OFS);
            cpu_rcap    = (next_phase[1:0] == LAST_OFS);
            cpu_ack_nxt = (next_phase[1:0] == LAST_OFS);
         end
         CPU_WRITE: begin
            cpu_we_nxt  = (next_phase[1:0] == 2'd1);
            cpu_ack_nxt = (next_phase[1:0] == LAST_OFS);
         end
         default: ;
      endcase
   end

   // Memory bus and result registers; CPU and video slots never overlap so
   // the address sources are mutually exclusive in time.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_oe     <= 1'b0;
         mem_we     <= 1'b0;
         cpu_ack    <= 1'b0;
         cpu_rdata  <= 8'h00;
         video_data <= 8'h00;
         mem_addr   <= '0;
         mem_wdata  <= 8'h00;
      end else begin
         mem_oe  <= cpu_oe_nxt | ram_oe_nxt | rom_oe_nxt;
         mem_we  <= cpu_we_nxt;
         cpu_ack <= cpu_ack_nxt;
         if (cpu_rcap)
            cpu_rdata <= mem_rdata;
         if (ram_cap || rom_cap)
            video_data <= mem_rdata;
         if (cpu_grant)
            mem_addr <= {{(ADDR_WIDTH-16){1'b0}}, cpu_addr};
         else if (ram_load)
            mem_addr <= ram_addr;
         else if (rom_load)
            mem_addr <= rom_addr;
         if (cpu_grant && cpu_we)
            mem_wdata <= cpu_wdata;
      end
   end

   video_fetch_slot #(
      .BASE         (VRAM_SLOT),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .VRAM_BASE    (VRAM_BASE),
      .CHARROM_BASE (CHARROM_BASE)
   ) u_ram_slot (
      .clk        (clk),
      .reset_n    (reset_n),
      .next_phase (next_phase),
      .video_en   (video_en),
      .video_addr (video_addr),
      .strobe     (video_ram_strobe),
      .addr_load  (ram_load),
      .addr_map   (ram_addr),
      .oe_next    (ram_oe_nxt),
      .capture    (ram_cap)
   );

   video_fetch_slot #(
      .BASE         (CROM_SLOT),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .VRAM_BASE    (VRAM_BASE),
      .CHARROM_BASE (CHARROM_BASE)
   ) u_rom_slot (
      .clk        (clk),
      .reset_n    (reset_n),
      .next_phase (next_phase),
      .video_en   (video_en),
      .video_addr (video_addr),
      .strobe     (video_rom_strobe),
      .addr_load  (rom_load),
      .addr_map   (rom_addr),
      .oe_next    (rom_oe_nxt),
      .capture    (rom_cap)
   );

endmodule

// File: tb/tb_video_mem_sequencer.sv
// Bench for video_mem_sequencer: directed table, corner sequences, random run.
// Outputs are sampled 1 time unit after each rising edge against a slot-level model.
// Inputs change only after sampling, so each edge sees stable stimulus.
module tb_video_mem_sequencer;

   logic        clk;
   logic        reset_n;
   logic        video_en;
   logic [11:0] video_addr;
   logic [7:0]  video_data;
   logic        video_ram_strobe;
   logic        video_rom_strobe;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic [16:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_oe;
   logic        mem_we;

   int vectors    = 0;
   int miscompares = 0;

   video_mem_sequencer dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .video_en         (video_en),
      .video_addr       (video_addr),
      .video_data       (video_data),
      .video_ram_strobe (video_ram_strobe),
      .video_rom_strobe (video_rom_strobe),
      .cpu_req          (cpu_req),
      .cpu_we           (cpu_we),
      .cpu_addr         (cpu_addr),
      .cpu_wdata        (cpu_wdata),
      .cpu_rdata        (cpu_rdata),
      .cpu_ack          (cpu_ack),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_rdata        (mem_rdata),
      .mem_oe           (mem_oe),
      .mem_we           (mem_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- slot-level reference model ----------------
   int          m_phase;
   bit          m_busy, m_wr, m_von;
   logic [16:0] m_maddr;
   logic [7:0]  m_mwd, m_vd, m_crd;

   task automatic model_reset();
      m_phase = 15; m_busy = 0; m_wr = 0; m_von = 0;
      m_maddr = '0; m_mwd = '0; m_vd = '0; m_crd = '0;
   endtask

   function automatic bit is_cpu_phase(int p);
      return (p < 4) || (p >= 8 && p < 12);
   endfunction

   task automatic model_edge();
      int p, k;
      p = (m_phase + 1) % 16;
      k = p % 4;
      if (is_cpu_phase(p)) begin
         if (k == 0) begin
            m_busy = cpu_req;
            m_wr   = cpu_we;
            if (cpu_req) begin
               m_maddr = {1'b0, cpu_addr};
               if (cpu_we) m_mwd = cpu_wdata;
            end
         end
         if (k == 3 && m_busy && !m_wr) m_crd = mem_rdata;
      end else begin
         if (k == 0) m_von = video_en;
         if (k == 1 && m_von)
            m_maddr = (video_addr[11] ? 17'h10000 : 17'h08000) + {6'd0, video_addr[10:0]};
         if (k == 3 && m_von) m_vd = mem_rdata;
      end
      m_phase = p;
   endtask

   function automatic bit exp_ack();
      return is_cpu_phase(m_phase) && m_busy && (m_phase % 4 == 3);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (model phase %0d, t=%0t)", name, act, exp, m_phase, $time);
      end
   endtask

   task automatic compare_all();
      int  k;
      bit  cpu;
      k   = m_phase % 4;
      cpu = is_cpu_phase(m_phase);
      chk("ram_strobe", 32'(video_ram_strobe), 32'(m_von && m_phase >= 4 && m_phase < 8));
      chk("rom_strobe", 32'(video_rom_strobe), 32'(m_von && m_phase >= 12));
      chk("mem_oe", 32'(mem_oe), 32'(cpu ? (m_busy && !m_wr && k <= 2) : (m_von && k >= 1)));
      chk("mem_we", 32'(mem_we), 32'(cpu && m_busy && m_wr && k == 1));
      chk("cpu_ack", 32'(cpu_ack), 32'(exp_ack()));
      chk("mem_addr", 32'(mem_addr), 32'(m_maddr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_mwd));
      chk("video_data", 32'(video_data), 32'(m_vd));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(m_crd));
      chk("oe_we_excl", 32'(mem_oe && mem_we), 32'(0));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        ven;
      logic [11:0] vaddr;
      logic [7:0]  rdata;
      logic        req;
      logic        we;
      logic [15:0] caddr;
      logic [7:0]  cwd;
      logic        rs, os, oe, wen, ack;
      logic [16:0] maddr;
      logic [7:0]  mwd, vd;
   } vec_t;

   vec_t tbl[32];

   task automatic row(input int i, input logic ven, input logic [11:0] vaddr, input logic [7:0] rdata,
                      input logic req, input logic we, input logic [15:0] caddr, input logic [7:0] cwd,
                      input logic rs, input logic os, input logic oe, input logic wen, input logic ack,
                      input logic [16:0] maddr, input logic [7:0] mwd, input logic [7:0] vd);
      tbl[i].ven = ven; tbl[i].vaddr = vaddr; tbl[i].rdata = rdata;
      tbl[i].req = req; tbl[i].we = we; tbl[i].caddr = caddr; tbl[i].cwd = cwd;
      tbl[i].rs = rs; tbl[i].os = os; tbl[i].oe = oe; tbl[i].wen = wen; tbl[i].ack = ack;
      tbl[i].maddr = maddr; tbl[i].mwd = mwd; tbl[i].vd = vd;
   endtask

   initial begin
      // Frame 1: video only. RAM fetch of 005 returning 41, ROM fetch of 80A returning 66.
      for (int i = 0; i < 4; i++)  row(i, 1, 12'h005, 8'h41, 0, 0, 16'h0, 8'h0, 0,0,0,0,0, 17'h00000, 8'h00, 8'h00);
      row(4, 1, 12'h005, 8'h41, 0, 0, 16'h0, 8'h0, 1,0,0,0,0, 17'h00000, 8'h00, 8'h00);
      row(5, 1, 12'h005, 8'h41, 0, 0, 16'h0, 8'h0, 1,0,1,0,0, 17'h08005, 8'h00, 8'h00);
      row(6, 1, 12'h005, 8'h41, 0, 0, 16'h0, 8'h0, 1,0,1,0,0, 17'h08005, 8'h00, 8'h00);
      row(7, 1, 12'h005, 8'h41, 0, 0, 16'h0, 8'h0, 1,0,1,0,0, 17'h08005, 8'h00, 8'h41);
      for (int i = 8; i < 12; i++) row(i, 1, 12'h80A, 8'h66, 0, 0, 16'h0, 8'h0, 0,0,0,0,0, 17'h08005, 8'h00, 8'h41);
      row(12, 1, 12'h80A, 8'h66, 0, 0, 16'h0, 8'h0, 0,1,0,0,0, 17'h08005, 8'h00, 8'h41);
      row(13, 1, 12'h80A, 8'h66, 0, 0, 16'h0, 8'h0, 0,1,1,0,0, 17'h1000A, 8'h00, 8'h41);
      row(14, 1, 12'h80A, 8'h66, 0, 0, 16'h0, 8'h0, 0,1,1,0,0, 17'h1000A, 8'h00, 8'h41);
      row(15, 1, 12'h80A, 8'h66, 0, 0, 16'h0, 8'h0, 0,1,1,0,0, 17'h1000A, 8'h00, 8'h66);
      // Frame 2: video disabled; CPU write 8123<-5A, req rises during phase 2, granted at 8.
      for (int i = 16; i < 19; i++) row(i, 0, 12'h005, 8'h00, 0, 0, 16'h0, 8'h0, 0,0,0,0,0, 17'h1000A, 8'h00, 8'h66);
      for (int i = 19; i < 24; i++) row(i, 0, 12'h005, 8'h00, 1, 1, 16'h8123, 8'h5A, 0,0,0,0,0, 17'h1000A, 8'h00, 8'h66);
      row(24, 0, 12'h005, 8'h00, 1, 1, 16'h8123, 8'h5A, 0,0,0,0,0, 17'h08123, 8'h5A, 8'h66);
      row(25, 0, 12'h005, 8'h00, 1, 1, 16'h8123, 8'h5A, 0,0,0,1,0, 17'h08123, 8'h5A, 8'h66);
      row(26, 0, 12'h005, 8'h00, 1, 1, 16'h8123, 8'h5A, 0,0,0,0,0, 17'h08123, 8'h5A, 8'h66);
      row(27, 0, 12'h005, 8'h00, 1, 1, 16'h8123, 8'h5A, 0,0,0,0,1, 17'h08123, 8'h5A, 8'h66);
      for (int i = 28; i < 32; i++) row(i, 0, 12'h005, 8'h00, 0, 1, 16'h8123, 8'h5A, 0,0,0,0,0, 17'h08123, 8'h5A, 8'h66);

      // Reset state
      reset_n = 0; video_en = 0; video_addr = '0; cpu_req = 0; cpu_we = 0;
      cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
      model_reset();
      #1;
      compare_all();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
      reset_n = 1;

      for (int i = 0; i < 32; i++) begin
         video_en = tbl[i].ven; video_addr = tbl[i].vaddr; mem_rdata = tbl[i].rdata;
         cpu_req = tbl[i].req; cpu_we = tbl[i].we; cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd;
         step();
         chk("tbl_ram_strobe", 32'(video_ram_strobe), 32'(tbl[i].rs));
         chk("tbl_rom_strobe", 32'(video_rom_strobe), 32'(tbl[i].os));
         chk("tbl_mem_oe", 32'(mem_oe), 32'(tbl[i].oe));
         chk("tbl_mem_we", 32'(mem_we), 32'(tbl[i].wen));
         chk("tbl_cpu_ack", 32'(cpu_ack), 32'(tbl[i].ack));
         chk("tbl_mem_addr", 32'(mem_addr), 32'(tbl[i].maddr));
         chk("tbl_mem_wdata", 32'(mem_wdata), 32'(tbl[i].mwd));
         chk("tbl_video_data", 32'(video_data), 32'(tbl[i].vd));
      end

      // CPU read returning C3 in slot 0; result held through idle slots
      video_en = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234; mem_rdata = 8'hC3;
      step();
      chk("rd_oe_phase0", 32'(mem_oe), 32'd1);
      chk("rd_addr", 32'(mem_addr), 32'h01234);
      step(); step(); step();
      chk("rd_ack", 32'(cpu_ack), 32'd1);
      chk("rd_data", 32'(cpu_rdata), 32'hC3);
      cpu_req = 0; mem_rdata = 8'h55;
      repeat (12) step();
      chk("rd_hold", 32'(cpu_rdata), 32'hC3);
      step();
      chk("idle_slot_oe", 32'(mem_oe), 32'd0);

      // Reset during phase 1 of a read: no ack, reset values, restart at phase 0
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0042; mem_rdata = 8'h3C;
      for (int n = 0; n < 40 && !(m_phase == 1 && m_busy); n++) step();
      chk("reached_read_phase1", 32'(m_phase == 1 && m_busy), 32'd1);
      #2 reset_n = 0;
      #1;
      model_reset();
      compare_all();
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         chk("no_ack_in_reset", 32'(cpu_ack), 32'd0);
         chk("oe_low_in_reset", 32'(mem_oe), 32'd0);
      end
      @(negedge clk);
      reset_n = 1;
      step();
      chk("restart_grant_oe", 32'(mem_oe), 32'd1);
      chk("restart_grant_addr", 32'(mem_addr), 32'h00042);
      step(); step(); step();
      chk("restart_ack", 32'(cpu_ack), 32'd1);
      chk("restart_rdata", 32'(cpu_rdata), 32'h3C);
      cpu_req = 0;

      // Reset during a RAM strobe drops the strobe without waiting for a clock
      video_en = 1; video_addr = 12'h123;
      for (int n = 0; n < 40 && m_phase != 5; n++) step();
      chk("strobe_before_reset", 32'(video_ram_strobe), 32'd1);
      #2 reset_n = 0;
      #1;
      model_reset();
      chk("strobe_async_drop", 32'(video_ram_strobe), 32'd0);
      compare_all();
      @(negedge clk);
      reset_n = 1;

      // Randomized run with a protocol-respecting requester
      for (int n = 0; n < 3000; n++) begin
         video_en   = ($urandom_range(7) != 0);
         video_addr = 12'($urandom);
         mem_rdata  = 8'($urandom);
         if (!cpu_req) begin
            if ($urandom_range(2) == 0) begin
               cpu_req = 1; cpu_we = 1'($urandom);
               cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
            end
         end else if (exp_ack()) begin
            if ($urandom_range(1) == 0) cpu_req = 0;
            else begin
               cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
            end
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/video_mem_sequencer.md
# video_mem_sequencer

Time-slot sequencer for the shared video/character SRAM, directly upstream of the video generator. Divides each 1 MHz character period into four fixed 4-clock slots at 16 MHz: CPU, video RAM fetch, CPU, and character ROM fetch. Generates `video_ram_strobe` and `video_rom_strobe`, maps the video generator's 12-bit `addr_out` onto the physical memory bus, and returns held fetch data on `video_data`. Serves CPU accesses through a req/ack handshake.

## Interface
- `ADDR_WIDTH`, 17: physical memory address width.
- `VRAM_BASE`, 17'h08000: physical base of 2 KB video RAM.
- `CHARROM_BASE`, 17'h10000: physical base of 2 KB character ROM image.
- `clk`  in  1  16 MHz system clock (2× pixel clock); single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `video_en`  in  1  0 suppresses both video slots (no strobes, no memory cycles).
- `video_addr`  in  12  generator `addr_out`: [11]=0 RAM, [11]=1 ROM; [10:0] offset.
- `video_data`  out  8  last fetched byte, to generator `data_in`.
- `video_ram_strobe`  out  1  RAM fetch strobe.
- `video_rom_strobe`  out  1  ROM fetch strobe.
- `cpu_req`  in  1  level request, held until `cpu_ack`.
- `cpu_we`  in  1  1 = write.
- `cpu_addr`  in  16  CPU address, zero-extended to `ADDR_WIDTH`.
- `cpu_wdata`  in  8  write data.
- `cpu_rdata`  out  8  read data; valid with `cpu_ack` and held until the next ack.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `mem_addr`  out  `ADDR_WIDTH`  SRAM address.
- `mem_wdata`  out  8  SRAM write data.
- `mem_rdata`  in  8  SRAM read data.
- `mem_oe`  out  1  SRAM output enable, active-high.
- `mem_we`  out  1  SRAM write enable, active-high.

## Operation
- 4-bit `phase` counter, 0..15, free-running and wrapping 15→0. All outputs are registered.
- CPU slots, phases 0-3 and 8-11 (base b = 0 or 8):
  - Grant occurs at the edge entering b if `cpu_req`=1. That edge latches `cpu_addr`, `cpu_we`, and `cpu_wdata`.
  - Read: `mem_oe`=1 in phases b..b+2. `mem_rdata` is captured into `cpu_rdata` at the edge entering b+3.
  - Write: `mem_wdata` is driven in phases b..b+2. `mem_we`=1 in phase b+1 only.
  - `cpu_ack`=1 in phase b+3 for reads and writes.
  - No grant: the slot is idle.
- Video slots, phases 4-7 (RAM strobe) and 12-15 (ROM strobe), base v = 4 or 12, only when `video_en`=1:
  - Strobe high in phases v..v+3; rises entering v, falls entering v+4.
  - `mem_addr` is registered entering v+1, giving the generator phase v to update `video_addr`. Mapping: `video_addr[11]` ? `CHARROM_BASE` + [10:0] : `VRAM_BASE` + [10:0].
  - `mem_oe`=1 in phases v+1..v+3.
  - `video_data` <= `mem_rdata` entering v+3, so it is stable one full cycle before the strobe falls. It holds until the next video capture.
- Idle memory state: `mem_oe`=0, `mem_we`=0, `mem_addr` and `mem_wdata` hold their last values.
- `video_en` is sampled at each video slot base edge. A change mid-slot does not truncate the strobe.

## Timing
- Reset values: `phase`=15, so the first edge after release enters phase 0 and is a grant edge. All strobes, `mem_oe`, `mem_we`, `cpu_ack` = 0. `mem_addr`, `mem_wdata`, `video_data`, `cpu_rdata` = 0.
- CPU latency: 4 cycles from grant to ack. Worst-case wait for grant is 8 cycles.
- Handshake: the requester drops `cpu_req`, or presents a new access, before the next grant edge (4 cycles after ack). `cpu_req` still high at that edge is a new access.
- `cpu_req` rising mid-slot waits for the next base edge. There is no partial access.
- CPU and video slots never overlap. `mem_oe` and `mem_we` are never both 1.
- Reset mid-access: the access is abandoned and no `cpu_ack` is issued. Strobes drop immediately (asynchronously).
- Character rate is exactly `clk`/16. Strobe pulse width is 4 cycles (250 ns).

## Structure
- Package `video_mem_pkg`: slot base constants (0, 4, 8, 12), slot length 4, and default base addresses.
- The two CPU slots and the two video slots share logic, selected by `phase[3:2]`.
- One sub-module, `video_fetch_slot`: strobe/address/capture logic, instantiated twice (RAM, ROM).

## Test plan
- Reset released, `video_en`=1, `video_addr`=12'h005, `mem_rdata`=8'h41: `video_ram_strobe` is high phases 4-7, `mem_addr`=17'h08005 from phase 5, and `video_data`=8'h41 at phase 7.
- `video_addr`=12'h80A in ROM slot: `video_rom_strobe` is high phases 12-15, `mem_addr`=17'h1000A, `mem_oe` is high phases 13-15.
- CPU write 16'h8123 ← 8'h5A with `cpu_req` rising in phase 2: grant at phase 8, `mem_we` high only in phase 9, `cpu_ack` in phase 11.
- CPU read with `mem_rdata`=8'hC3: `cpu_rdata`=8'hC3 with `cpu_ack`, held through the following idle slots.
- `video_en`=0 for one frame: no strobes and `mem_oe` low in phases 4-7 and 12-15; CPU slots are unaffected.
- `reset_n` pulsed low in phase 1 of a read: no ack, outputs go to reset values, and the sequence restarts at phase 0.
